// File: rtl/mem_wb_pipe.sv
// Memory/writeback stage: branch resolution, sub-word load/store against an
// internal RAM with configurable load latency, registered writeback bundle.
module mem_wb_pipe #(
  parameter int ADDR_W  = 8,
  parameter int PC_W    = 5,
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       write_data,
  input  logic [2:0]        jump_type,
  input  logic              reg_wrenable,
  input  logic              mem_wrenable,
  input  logic              mem_to_reg,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [REG_W-1:0]  write_reg,
  output logic              wb_valid,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_reg_wrenable,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [31:0]       wb_write_data,
  output logic              should_jump,
  output logic              misalign
);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             wren;
    logic [REG_W-1:0] wreg;
    logic [31:0]      data;
    logic             jump;
    logic             mis;
  } wb_t;

  logic [31:0] mem [2**ADDR_W];

  state_t      state;
  logic [2:0]  cnt;
  wb_t         pend, nxt, emit_b;
  logic        accept, is_load, is_store, is_byte, is_half, mis, emit, mem_we;
  logic [1:0]  lane;
  logic [ADDR_W-1:0] idx;
  logic [31:0] rd_word, sh_word, ld_ext, wdat;
  logic [3:0]  be;
  logic        unused;

  // Address bits above the RAM are intentionally ignored, so addresses wrap.
  assign unused   = ^alu_res[31:ADDR_W+2];
  assign idx      = alu_res[ADDR_W+1:2];
  assign lane     = alu_res[1:0];
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign is_store = mem_wrenable;
  assign is_load  = mem_to_reg && !mem_wrenable;
  assign is_byte  = (mem_size == 2'b00);
  assign is_half  = (mem_size == 2'b01);
  assign mis      = (mem_wrenable || mem_to_reg) &&
                    ((is_half && lane[0]) || (!is_byte && !is_half && lane != 2'b00));
  assign rd_word  = mem[idx];
  assign sh_word  = rd_word >> {lane, 3'b000};
  assign mem_we   = accept && is_store && !mis;

  always_comb begin
    ld_ext = rd_word;
    if (is_byte)      ld_ext = {{24{!mem_unsigned && sh_word[7]}}, sh_word[7:0]};
    else if (is_half) ld_ext = {{16{!mem_unsigned && sh_word[15]}}, sh_word[15:0]};
    be   = 4'b1111;
    wdat = write_data;
    if (is_byte) begin
      be   = 4'b0001 << lane;
      wdat = {4{write_data[7:0]}};
    end else if (is_half) begin
      be   = 4'b0011 << lane;
      wdat = {2{write_data[15:0]}};
    end
  end

  always_comb begin
    nxt      = '0;
    nxt.pc   = pc;
    nxt.wren = reg_wrenable;
    nxt.wreg = write_reg;
    nxt.mis  = mis;
    case (jump_type)
      3'b001:  nxt.jump = 1'b1;
      3'b100:  nxt.jump = (alu_res == 32'd0);
      3'b110:  nxt.jump = (alu_res != 32'd0);
      3'b101:  nxt.jump = alu_res[31];
      3'b111:  nxt.jump = !alu_res[31];
      default: nxt.jump = 1'b0;
    endcase
    if (jump_type == 3'b001) nxt.data = write_data;
    else if (is_load)        nxt.data = mis ? 32'd0 : ld_ext;
    else                     nxt.data = alu_res;
  end

  // Loads snapshot RAM data at accept; the wait state only delays delivery.
  assign emit   = (state == IDLE && accept && !(is_load && MEM_LAT > 1)) ||
                  (state == LOAD_WAIT && cnt == 3'd1);
  assign emit_b = (state == IDLE) ? nxt : pend;

  always_ff @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wdat[b*8 +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      pend            <= '0;
      wb_valid        <= 1'b0;
      should_jump     <= 1'b0;
      misalign        <= 1'b0;
      wb_reg_wrenable <= 1'b0;
      wb_write_data   <= '0;
      wb_write_reg    <= '0;
      wb_pc           <= '0;
    end else begin
      wb_valid        <= emit;
      should_jump     <= emit && emit_b.jump;
      misalign        <= emit && emit_b.mis;
      wb_reg_wrenable <= emit && emit_b.wren;
      if (emit) begin
        wb_write_data <= emit_b.data;
        wb_write_reg  <= emit_b.wreg;
        wb_pc         <= emit_b.pc;
      end
      case (state)
        IDLE:
          if (accept && is_load && MEM_LAT > 1) begin
            state <= LOAD_WAIT;
            cnt   <= 3'(MEM_LAT - 1);
            pend  <= nxt;
          end
        LOAD_WAIT:
          if (cnt == 3'd1) state <= IDLE;
          else             cnt   <= cnt - 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised memory/writeback stage for the pipelined CPU.
- Takes the execute-stage result and resolves branches, including the new signed compares (blt/bge).
- Performs sub-word loads and stores against an internal data RAM whose read latency is configurable.
- Drives a registered, valid-qualified writeback bundle and uses a ready/valid handshake to stall upstream while a multi-cycle load is in flight.

Parameters:
- ADDR_W, 8: word-address width; RAM depth is 2**ADDR_W 32-bit words.
- PC_W, 5: program counter width.
- REG_W, 5: register index width.
- MEM_LAT, 1: load latency in cycles, from accept to wb_valid; legal range 1..4.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- pc  in  PC_W  instruction PC; pipelined to wb_pc.
- alu_res  in  32  ALU result, which is also the byte address.
- write_data  in  32  store data, or pc+1 for jal/jalr.
- jump_type  in  3  000 none, 001 jal/jalr, 100 beq, 110 bne, 101 blt, 111 bge.
- reg_wrenable  in  1  instruction writes the register file.
- mem_wrenable  in  1  store.
- mem_to_reg  in  1  load.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned  in  1  zero-extend sub-word loads.
- write_reg  in  REG_W  destination register.
- wb_valid  out  1  writeback bundle valid; one-cycle pulse per instruction.
- wb_pc  out  PC_W  PC of the retiring instruction.
- wb_reg_wrenable  out  1  qualified by wb_valid.
- wb_write_reg  out  REG_W  destination register.
- wb_write_data  out  32  writeback value.
- should_jump  out  1  branch/jump taken; qualified by wb_valid.
- misalign  out  1  one-cycle pulse: misaligned access detected.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, counter=0.
  - wb_valid, should_jump, misalign, wb_reg_wrenable = 0.
  - wb_write_data, wb_write_reg, wb_pc = 0.
  - RAM contents are not cleared.
- rst mid-load: the pending load is dropped and no wb_valid is produced for it.
- Accept: in_valid && in_ready.
- in_ready = (state==IDLE) && !rst.
- FSM: IDLE, LOAD_WAIT.
  - Accepting a load with MEM_LAT>1: IDLE->LOAD_WAIT, counter=MEM_LAT-1.
  - LOAD_WAIT decrements the counter each cycle.
  - When counter reaches 1 and then expires, the stage returns to IDLE in the same cycle that wb_valid rises.
  - in_ready is low for exactly MEM_LAT-1 cycles after a load is accepted.
- Latency:
  - Non-load: wb_valid is 1 cycle after accept.
  - Load: wb_valid is MEM_LAT cycles after accept.
  - MEM_LAT=1 gives no stall, i.e. back-to-back loads at full rate.
- No accept and no pending load: wb_valid=0 and should_jump=0 next cycle.
- Addressing: word index = alu_res[ADDR_W+1:2]; byte lane = alu_res[1:0]; upper address bits are ignored, so addresses wrap modulo the RAM size.
- Alignment:
  - Half requires alu_res[0]=0.
  - Word requires alu_res[1:0]=0.
  - A misaligned store is suppressed (no RAM write).
  - A misaligned load returns 0.
  - Either case pulses misalign together with the instruction's wb_valid.
- Stores:
  - Write only the addressed bytes, taken from the low bits of write_data; other bytes are preserved.
  - The RAM write commits at the accept edge.
  - A load accepted on the next cycle to the same word returns the new data.
- Loads:
  - The addressed byte/half is extracted and shifted to bit 0.
  - Sign-extended unless mem_unsigned=1.
  - Word loads are returned unmodified.
- mem_wrenable && mem_to_reg together: the store is performed, the load is ignored, and the instruction is treated as a non-load.
- Branch resolution, registered with the bundle:
  - beq: alu_res==0.
  - bne: alu_res!=0.
  - blt: alu_res[31]==1.
  - bge: alu_res[31]==0.
  - 001: always taken.
  - 000: not taken.
  - Other codes (010, 011): not taken.
- Writeback data, in priority order:
  - jump_type==001 gives write_data.
  - else load gives the extended RAM data.
  - else alu_res.
- wb_reg_wrenable = reg_wrenable of the accepted instruction.

Test Plan:
- sw 0xDEADBEEF @ addr 0x10, then next-cycle lw @0x10, MEM_LAT=1 -> wb_write_data=0xDEADBEEF one cycle after the lw accept; in_ready never drops.
- After the store above: sb 0x7F @0x11, then lb @0x11 -> 0x0000007F. lbu @0x13 -> 0x000000DE. lb @0x13 -> 0xFFFFFFDE. lh @0x12 -> 0xFFFFDEAD.
- MEM_LAT=3, lw accepted at cycle t, in_valid held high -> in_ready low at t+1,t+2; wb_valid at t+3; next bundle accepted at t+3.
- jump_type: 110 with alu_res=5 -> should_jump=1. 100 with alu_res=5 -> 0. 101 with alu_res=0xFFFFFFFF -> 1. 111 with alu_res=0xFFFFFFFF -> 0. 001 with write_data=7 -> should_jump=1, wb_write_data=7.
- sh @0x11 -> misalign pulse, word 0x10 unchanged. lw @0x12 -> misalign pulse, wb_write_data=0.
- MEM_LAT=4, rst asserted 2 cycles after a lw accept -> no wb_valid for that load, in_ready=1 the cycle after rst deasserts, all outputs 0.
